wide_add_sequencer: RTL and testbench
=====================================

# wide_add_sequencer

Byte-serial controller that sequences the shared 8-bit hybrid carry-lookahead adder (`hybridadder8_struct`) to perform NBYTES-wide addition and subtraction. It accepts one operand pair through a valid/ready request port. It then drives the adder one byte per cycle, least-significant byte first, chaining the carry through a register. It returns the full-width result, carry-out and signed overflow through a valid/ready response port. The adder sits outside this block; the block connects to its Xi/Yi/C0 inputs and its Si/C8 outputs combinationally.

## Interface
- NBYTES, 4, operand width in bytes; legal values are 1 to 16. W = 8*NBYTES.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- req_valid  in  1  request operands are valid.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_a  in  W  operand A.
- req_b  in  W  operand B.
- req_sub  in  1  0 computes A+B; 1 computes A−B.
- rsp_valid  out  1  result is valid; high only in DONE.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  W  result word, registered.
- rsp_cout  out  1  carry out of the MSB. For subtract, 1 means no borrow (A ≥ B unsigned).
- rsp_ovf  out  1  two's-complement overflow.
- add_x  out  8  drives adder Xi.
- add_y  out  8  drives adder Yi.
- add_c0  out  1  drives adder C0.
- add_s  in  8  adder Si.
- add_c8  in  1  adder C8.

## Operation
- **States:** IDLE, RUN, DONE. Reset forces IDLE.
- **IDLE:**
  - req_ready = 1.
  - On req_valid at a clock edge:
    - latch req_a into opA.
    - latch req_b ^ {W{req_sub}} into opB.
    - latch req_sub into the sub flag.
    - idx ← 0.
    - carry ← req_sub.
    - go to RUN.
- **RUN:**
  - Adder drive: add_x = opA[8*idx +: 8], add_y = opB[8*idx +: 8], add_c0 = carry.
  - Each edge:
    - rsp_sum[8*idx +: 8] ← add_s.
    - carry ← add_c8.
    - idx ← idx+1.
  - On the edge where idx == NBYTES−1:
    - rsp_cout ← add_c8.
    - rsp_ovf ← (add_x[7] ~^ add_y[7]) & (add_s[7] ^ add_x[7]), i.e. both adder inputs have the same sign and the sum's sign differs.
    - go to DONE.
- **DONE:**
  - rsp_valid = 1.
  - rsp_sum, rsp_cout and rsp_ovf are held stable.
  - On rsp_ready, go to IDLE.
  - req_valid is ignored because req_ready = 0.
- **Adder drive outside RUN:** add_x = 0, add_y = 0, add_c0 = 0.
- **Width rules:**
  - The idx register is clog2(NBYTES) bits, minimum 1.
  - idx never wraps inside an operation; it is reset to 0 on each accept.
  - With NBYTES = 1, RUN lasts exactly one cycle.
- **Result bytes:** rsp_sum bytes are overwritten in order during RUN. Bytes not yet written keep the previous result; this is only visible while rsp_valid = 0.

## Timing
- **Reset values (all synchronous):**
  - state = IDLE.
  - req_ready = 0 during the rst cycle, then 1.
  - rsp_valid = 0.
  - rsp_sum = 0, rsp_cout = 0, rsp_ovf = 0.
  - idx = 0, carry = 0.
  - add_x = 0, add_y = 0, add_c0 = 0.
- **Latency:** with the accept edge as edge 0, rsp_valid rises after edge NBYTES. That is 4 cycles for the default NBYTES.
- **Throughput:**
  - One operation per NBYTES+2 cycles when rsp_ready is held high: NBYTES in RUN, 1 in DONE, 1 in IDLE.
  - No request is accepted in the same cycle as a response handshake.
- **Handshake:**
  - A transfer occurs only when valid & ready are both high at an edge.
  - rsp_valid stays high with stable data until it is accepted.
- **Adder path:** a combinational path runs add_x/add_y/add_c0 → adder → add_s/add_c8 → registers. It must close within one clk period.
- **Reset mid-operation:**
  - rst in RUN or DONE aborts the operation; no response is produced.
  - All outputs take their reset values on that edge.
- **Simultaneous events:** rst takes priority over req_valid and rsp_ready.

## Test plan
- Add, NBYTES = 4: 0x000000FF + 0x00000001 → rsp_sum = 0x00000100, cout = 0, ovf = 0. rsp_valid rises exactly 4 cycles after the accept edge.
- Carry chain through all bytes: 0xFFFFFFFF + 0x00000001 → rsp_sum = 0x00000000, cout = 1, ovf = 0.
- Signed overflow:
  - 0x7FFFFFFF + 0x00000001 → rsp_sum = 0x80000000, ovf = 1, cout = 0.
  - 0x80000000 + 0x80000000 → rsp_sum = 0, ovf = 1, cout = 1.
- Subtract:
  - 5 − 7 → rsp_sum = 0xFFFFFFFE, cout = 0, ovf = 0.
  - 7 − 5 → rsp_sum = 0x00000002, cout = 1.
  - 0x80000000 − 1 → rsp_sum = 0x7FFFFFFF, ovf = 1.
- Backpressure: hold rsp_ready = 0 for 3 cycles in DONE, with req_valid high and new operands presented.
  - rsp_valid and the result stay constant.
  - req_ready = 0 and the new request is not accepted.
  - On the rsp_ready edge the block returns to IDLE; the pending request is accepted on the next edge.
- Reset during RUN: assert rst on the 2nd RUN cycle.
  - The next cycle shows rsp_valid = 0, add_x/add_y/add_c0 = 0, and req_ready = 0 while rst is high.
  - req_ready = 1 after rst is released.
  - A following 0x12345678 + 0x11111111 returns 0x23456789.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Byte-serial sequencer that drives an external 8-bit adder to add or subtract
// NBYTES-wide operands, least-significant byte first, with a registered carry.
module wide_add_sequencer #(
   parameter int NBYTES = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_req_valid,
   output logic                o_req_ready,
   input  logic [8*NBYTES-1:0] i_req_a,
   input  logic [8*NBYTES-1:0] i_req_b,
   input  logic                i_req_sub,
   output logic                o_rsp_valid,
   input  logic                i_rsp_ready,
   output logic [8*NBYTES-1:0] o_rsp_sum,
   output logic                o_rsp_cout,
   output logic                o_rsp_ovf,
   output logic [7:0]          o_add_x,
   output logic [7:0]          o_add_y,
   output logic                o_add_c0,
   input  logic [7:0]          i_add_s,
   input  logic                i_add_c8
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   logic [1:0]    r_state;
   logic [W-1:0]  r_op_a;
   logic [W-1:0]  r_op_b;
   logic [IW-1:0] r_idx;
   logic          r_carry;
   logic [W-1:0]  r_sum;
   logic          r_cout;
   logic          r_ovf;

   logic [IW+2:0] w_bit;
   logic [7:0]    w_x;
   logic [7:0]    w_y;
   logic          w_c0;
   logic          w_run;

   assign w_run = (r_state == S_RUN);
   assign w_bit = {r_idx, 3'b000};

   // NOTE: every output of this block gets a default before the branch, so no latch is inferred.
   always_comb begin
      w_x  = 8'h00;
      w_y  = 8'h00;
      w_c0 = 1'b0;
      if (w_run) begin
         w_x  = r_op_a[w_bit +: 8];
         w_y  = r_op_b[w_bit +: 8];
         w_c0 = r_carry;
      end
   end

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_op_a  <= '0;
         r_op_b  <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_op_a  <= i_req_a;
                  r_op_b  <= i_req_b ^ {W{i_req_sub}};
                  r_idx   <= '0;
                  r_carry <= i_req_sub;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_sum[w_bit +: 8] <= i_add_s;
               r_carry           <= i_add_c8;
               if (r_idx == LAST_IDX) begin
                  // Overflow: both adder inputs share a sign that the sum does not.
                  r_cout  <= i_add_c8;
                  r_ovf   <= (w_x[7] ~^ w_y[7]) & (i_add_s[7] ^ w_x[7]);
                  r_state <= S_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DONE: begin
               if (i_rsp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_req_ready = (r_state == S_IDLE) & ~i_rst;
   assign o_rsp_valid = (r_state == S_DONE);
   assign o_rsp_sum   = r_sum;
   assign o_rsp_cout  = r_cout;
   assign o_rsp_ovf   = r_ovf;
   assign o_add_x     = w_x;
   assign o_add_y     = w_y;
   assign o_add_c0    = w_c0;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer with a behavioural 8-bit adder in the loop.
module tb_wide_add_sequencer;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic         req_sub;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_sum;
   logic         rsp_cout;
   logic         rsp_ovf;
   logic [7:0]   add_x;
   logic [7:0]   add_y;
   logic         add_c0;
   logic [7:0]   add_s;
   logic         add_c8;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Stand-in for the shared 8-bit adder.
   assign {add_c8, add_s} = {1'b0, add_x} + {1'b0, add_y} + {8'h00, add_c0};

   wide_add_sequencer #(.NBYTES(NBYTES)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .i_req_sub   (req_sub),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_sum   (rsp_sum),
      .o_rsp_cout  (rsp_cout),
      .o_rsp_ovf   (rsp_ovf),
      .o_add_x     (add_x),
      .o_add_y     (add_y),
      .o_add_c0    (add_c0),
      .i_add_s     (add_s),
      .i_add_c8    (add_c8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits (at falling edges) for rsp_valid; returns the number of edges since the accept edge.
   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic accept_rsp(input string tag);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, " valid_drop"}, 64'(rsp_valid), 64'd0);
      check({tag, " ready_back"}, 64'(req_ready), 64'd1);
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] e_sum, input logic e_cout,
                        input logic e_ovf);
      int n;
      @(negedge clk);
      check({tag, " req_ready"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_sub   = sub;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      wait_rsp(n);
      check({tag, " latency"}, 64'(n), 64'(NBYTES));
      check({tag, " sum"},     64'(rsp_sum),  64'(e_sum));
      check({tag, " cout"},    64'(rsp_cout), 64'(e_cout));
      check({tag, " ovf"},     64'(rsp_ovf),  64'(e_ovf));
      accept_rsp(tag);
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_sub   = 1'b0;
      rsp_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst req_ready", 64'(req_ready), 64'd0);
      check("rst rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst rsp_sum",   64'(rsp_sum),   64'd0);
      check("rst cout_ovf",  64'({rsp_cout, rsp_ovf}), 64'd0);
      check("rst add_drive", 64'({add_x, add_y, add_c0}), 64'd0);
      rst = 1'b0;
      #1;
      check("post-rst req_ready", 64'(req_ready), 64'd1);

      do_op("add_ff_1",   32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
      do_op("carry_all",  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
      do_op("ovf_pos",    32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
      do_op("ovf_neg",    32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
      do_op("sub_5_7",    32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
      do_op("sub_7_5",    32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0);
      do_op("sub_ovf",    32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

      // Backpressure: response held while a new request waits.
      @(negedge clk);
      req_valid = 1'b1;
      req_a     = 32'h00000010;
      req_b     = 32'h00000020;
      req_sub   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_a = 32'h00000001;
      req_b = 32'h00000002;
      wait_rsp(n);
      check("bp latency", 64'(n), 64'(NBYTES));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp hold valid", 64'(rsp_valid), 64'd1);
         check("bp hold sum",   64'(rsp_sum),   64'h30);
         check("bp req_ready",  64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("bp idle valid", 64'(rsp_valid), 64'd0);
      check("bp idle ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("bp accepted", 64'(req_ready), 64'd0);
      wait_rsp(n);
      check("bp2 latency", 64'(n), 64'(NBYTES));
      check("bp2 sum",     64'(rsp_sum), 64'h3);
      accept_rsp("bp2");

      // Reset on the second RUN cycle.
      @(negedge clk);
      req_valid = 1'b1;
      req_a     = 32'hAABBCCDD;
      req_b     = 32'h11223344;
      req_sub   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("run1 drive", 64'({add_x, add_y, add_c0}), 64'({8'hDD, 8'h44, 1'b0}));
      @(posedge clk);
      @(negedge clk);
      check("run2 drive", 64'({add_x, add_y, add_c0}), 64'({8'hCC, 8'h33, 1'b1}));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid-rst valid",  64'(rsp_valid), 64'd0);
      check("mid-rst drive",  64'({add_x, add_y, add_c0}), 64'd0);
      check("mid-rst ready",  64'(req_ready), 64'd0);
      check("mid-rst sum",    64'(rsp_sum), 64'd0);
      rst = 1'b0;
      #1;
      check("mid-rst release", 64'(req_ready), 64'd1);
      do_op("after_rst", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
